// File: rtl/sigmoid_grad_fixed.sv
// Sigmoid backward pass: grad_out = g * s * (1 - s) in signed fixed point.
// Valid/ready pipeline with a global stall and a sticky range error on out-of-range s.
module sigmoid_grad_fixed #(
   parameter int BIT_WIDTH     = 32,
   parameter int DECIMAL_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] sig_in,
   input  logic [BIT_WIDTH-1:0] grad_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] grad_out,
   output logic                 range_err,
   input  logic                 clear_err
);

   localparam logic [BIT_WIDTH-1:0] ONE = {{(BIT_WIDTH-1){1'b0}}, 1'b1} << DECIMAL_WIDTH;

   logic en;
   logic accept;
   logic in_clamp;

   // Input register stage ahead of the clamp stage
   logic                 v0;
   logic [BIT_WIDTH-1:0] s0_sig;
   logic [BIT_WIDTH-1:0] s0_grad;

   // Clamp stage
   logic                 v1;
   logic [BIT_WIDTH-1:0] s1_sc;
   logic [BIT_WIDTH-1:0] s1_om;
   logic [BIT_WIDTH-1:0] s1_grad;
   logic [BIT_WIDTH-1:0] sc_next;

   // s*(1-s) stage
   logic                   v2;
   logic [BIT_WIDTH-1:0]   s2_p;
   logic [BIT_WIDTH-1:0]   s2_grad;
   logic [2*BIT_WIDTH-1:0] prod_u;

   // g*p stage
   logic                          v3;
   logic signed [2*BIT_WIDTH-1:0] g_ext;
   logic signed [2*BIT_WIDTH-1:0] p_ext;
   logic signed [2*BIT_WIDTH-1:0] prod_s;
   logic signed [2*BIT_WIDTH-1:0] q;

   logic unused_bits;

   assign en        = !out_valid || out_ready;
   assign in_ready  = en;
   assign accept    = in_valid && en;
   assign out_valid = v3;

   // Range check looks at the live input so range_err updates on the acceptance edge
   assign in_clamp = sig_in[BIT_WIDTH-1] || (sig_in > ONE);

   always_comb begin
      sc_next = s0_sig;
      if (s0_sig[BIT_WIDTH-1]) begin
         sc_next = '0;
      end else if (s0_sig > ONE) begin
         sc_next = ONE;
      end
   end

   assign prod_u = {{BIT_WIDTH{1'b0}}, s1_sc} * {{BIT_WIDTH{1'b0}}, s1_om};

   assign g_ext  = {{BIT_WIDTH{s2_grad[BIT_WIDTH-1]}}, s2_grad};
   assign p_ext  = {{BIT_WIDTH{1'b0}}, s2_p};
   assign prod_s = g_ext * p_ext;
   assign q      = prod_s >>> DECIMAL_WIDTH;

   assign unused_bits = ^{prod_u[2*BIT_WIDTH-1:DECIMAL_WIDTH+BIT_WIDTH],
                          prod_u[DECIMAL_WIDTH-1:0], q[2*BIT_WIDTH-1:BIT_WIDTH]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v0       <= 1'b0;
         s0_sig   <= '0;
         s0_grad  <= '0;
         v1       <= 1'b0;
         s1_sc    <= '0;
         s1_om    <= '0;
         s1_grad  <= '0;
         v2       <= 1'b0;
         s2_p     <= '0;
         s2_grad  <= '0;
         v3       <= 1'b0;
         grad_out <= '0;
      end else if (en) begin
         v0 <= in_valid;
         if (in_valid) begin
            s0_sig  <= sig_in;
            s0_grad <= grad_in;
         end
         v1 <= v0;
         if (v0) begin
            s1_sc   <= sc_next;
            s1_om   <= ONE - sc_next;
            s1_grad <= s0_grad;
         end
         v2 <= v1;
         if (v1) begin
            s2_p    <= prod_u[DECIMAL_WIDTH +: BIT_WIDTH];
            s2_grad <= s1_grad;
         end
         v3 <= v2;
         if (v2) begin
            grad_out <= q[BIT_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         range_err <= 1'b0;
      end else if (accept && in_clamp) begin
         range_err <= 1'b1;
      end else if (clear_err) begin
         range_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sigmoid_grad_fixed.sv
// Directed bench for sigmoid_grad_fixed: values, floor rounding, clamping,
// backpressure ordering and asynchronous reset.
module tb_sigmoid_grad_fixed;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] sig_in;
   logic [31:0] grad_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] grad_out;
   logic        range_err;
   logic        clear_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sigmoid_grad_fixed #(.BIT_WIDTH(32), .DECIMAL_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .sig_in(sig_in), .grad_in(grad_in), .out_valid(out_valid), .out_ready(out_ready),
      .grad_out(grad_out), .range_err(range_err), .clear_err(clear_err)
   );

   // Called at a falling edge; returns at the falling edge after the acceptance edge.
   task automatic push(input logic [31:0] s, input logic [31:0] g);
      sig_in   = s;
      grad_in  = g;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int k);
      k = 0;
      while (!out_valid && k < 12) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; sig_in = '0; grad_in = '0;
      out_ready = 1'b1; clear_err = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (grad_out !== 32'd0) begin errors++; $display("FAIL reset_grad_out: got %h expected 0", grad_out); end
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL reset_range_err: got %b expected 0", range_err); end
      reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_basic();
      int k;
      push(32'd32768, 32'd65536);
      wait_out(k);
      checks++; if (k !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", k); end
      checks++; if (grad_out !== 32'd16384) begin errors++; $display("FAIL basic_value: got %h expected %h", grad_out, 32'd16384); end
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL basic_range_err: got %b expected 0", range_err); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_no_dup: got %b expected 0", out_valid); end
   endtask

   task automatic test_values();
      logic [31:0] s_t [6] = '{32'd49152, 32'd6554, 32'd6554, 32'd16384, 32'd65536, 32'd0};
      logic [31:0] g_t [6] = '{32'hFFFE0000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h00030000, 32'd65536, 32'h00012345};
      logic [31:0] e_t [6] = '{32'hFFFFA000, 32'hFFFFE8F6, 32'hFFFFFFFF, 32'h00009000, 32'd0, 32'd0};
      int k;
      for (int i = 0; i < 6; i++) begin
         push(s_t[i], g_t[i]);
         wait_out(k);
         checks++; if (k !== 3) begin errors++; $display("FAIL value_latency[%0d]: got %0d expected 3", i, k); end
         checks++; if (grad_out !== e_t[i]) begin errors++; $display("FAIL value[%0d]: got %h expected %h", i, grad_out, e_t[i]); end
         @(negedge clk);
      end
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL boundary_range_err: got %b expected 0", range_err); end
   endtask

   task automatic test_range();
      int k;
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL range_pre: got %b expected 0", range_err); end
      push(32'hFFFFFF9C, 32'd65536);
      checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_neg_set: got %b expected 1", range_err); end
      wait_out(k);
      checks++; if (grad_out !== 32'd0) begin errors++; $display("FAIL range_neg_value: got %h expected 0", grad_out); end
      @(negedge clk);
      push(32'd131072, 32'd65536);
      wait_out(k);
      checks++; if (grad_out !== 32'd0) begin errors++; $display("FAIL range_big_value: got %h expected 0", grad_out); end
      @(negedge clk);
      clear_err = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear_err = 1'b0;
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL range_clear: got %b expected 0", range_err); end
      clear_err = 1'b1;
      push(32'hFFFFFF9C, 32'd65536);
      clear_err = 1'b0;
      checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_set_wins: got %b expected 1", range_err); end
      clear_err = 1'b1;
      push(32'd32768, 32'd65536);
      clear_err = 1'b0;
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL range_clear_legal: got %b expected 0", range_err); end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [31:0] s_t [6] = '{32'd32768, 32'd49152, 32'd6554, 32'd16384, 32'd6554, 32'd65536};
      logic [31:0] g_t [6] = '{32'd65536, 32'hFFFE0000, 32'hFFFF0000, 32'h00030000, 32'hFFFFFFFF, 32'd65536};
      logic [31:0] e_t [6] = '{32'd16384, 32'hFFFFA000, 32'hFFFFE8F6, 32'h00009000, 32'hFFFFFFFF, 32'd0};
      int acc = 0;
      int n = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sig_in   = s_t[(acc < 6) ? acc : 5];
         grad_in  = g_t[(acc < 6) ? acc : 5];
         in_valid = 1'b1;
         if (in_ready) acc++;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
      checks++; if (grad_out !== e_t[0]) begin errors++; $display("FAIL bp_head: got %h expected %h", grad_out, e_t[0]); end
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", out_valid); end
      checks++; if (grad_out !== e_t[0]) begin errors++; $display("FAIL bp_hold_value: got %h expected %h", grad_out, e_t[0]); end
      // Restart: item 4 is offered in the same cycle out_ready rises
      out_ready = 1'b1;
      sig_in    = s_t[4];
      grad_in   = g_t[4];
      in_valid  = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_restart_ready: got %b expected 1", in_ready); end
      for (int c = 0; c < 16; c++) begin
         if (out_valid) begin
            if (n < 5) begin
               checks++; if (grad_out !== e_t[n]) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", n, grad_out, e_t[n]); end
            end
            n++;
         end
         @(negedge clk);
         in_valid = 1'b0;
      end
      checks++; if (n !== 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", n); end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] s_t [3] = '{32'd32768, 32'd49152, 32'd16384};
      logic [31:0] g_t [3] = '{32'd65536, 32'hFFFE0000, 32'h00030000};
      int seen = 0;
      int k;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sig_in = s_t[i]; grad_in = g_t[i]; in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      checks++; if (out_valid !== 1'b1 || grad_out !== 32'd16384) begin errors++; $display("FAIL mid_pre: got valid=%b data=%h expected valid=1 data=%h", out_valid, grad_out, 32'd16384); end
      #1;
      reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
      checks++; if (grad_out !== 32'd0) begin errors++; $display("FAIL mid_async_data: got %h expected 0", grad_out); end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_discard: got %0d stale outputs expected 0", seen); end
      push(32'd49152, 32'hFFFE0000);
      wait_out(k);
      checks++; if (k !== 3) begin errors++; $display("FAIL mid_latency: got %0d expected 3", k); end
      checks++; if (grad_out !== 32'hFFFFA000) begin errors++; $display("FAIL mid_value: got %h expected %h", grad_out, 32'hFFFFA000); end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_values();
      test_range();
      test_backpressure();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sigmoid_grad_fixed.md
# sigmoid_grad_fixed

Backward-pass companion to the fixed-point sigmoid unit in the SIMD datapath. It computes the sigmoid gradient g·s·(1−s) from a stored forward output s and an upstream gradient g. It is a 3-stage valid/ready pipeline with input range checking, and it sits in the SIMD lanes next to the forward activation for on-chip training.

## Interface
- BIT_WIDTH, 32: word width of all data ports; signed two's complement fixed point.
- DECIMAL_WIDTH, 16: fractional bits. 1.0 = 2^DECIMAL_WIDTH (65536 at defaults).
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  sig_in/grad_in valid this cycle.
- in_ready  output  1  pipeline accepts input this cycle.
- sig_in  input  BIT_WIDTH  forward sigmoid output s; legal range [0, 1.0].
- grad_in  input  BIT_WIDTH  upstream gradient g, signed.
- out_valid  output  1  grad_out valid.
- out_ready  input  1  downstream accepts grad_out.
- grad_out  output  BIT_WIDTH  g·s·(1−s), signed.
- range_err  output  1  sticky; set when any accepted sig_in was outside [0, 1.0].
- clear_err  input  1  synchronous clear of range_err.

## Operation
- Global stall enable: en = !out_valid || out_ready. in_ready = en, combinationally.
- An input is accepted when in_valid && in_ready. All stage registers advance only when en=1. Each stage carries a valid bit; bubbles propagate.
- Stage 1 (clamp):
  - s<0 (MSB set) → s_c = 0.
  - s > 1.0 → s_c = 1.0.
  - Otherwise s_c = s.
  - Register s_c, om = 1.0 − s_c, g, v1.
  - A clamp on an accepted input sets range_err at the same edge.
- Stage 2: p = (s_c · om) >> DECIMAL_WIDTH. This is an unsigned 2·BIT_WIDTH product, truncated, so p ∈ [0, 0.25]. Register p, g, v2.
- Stage 3: q = (g · p) as a signed 2·BIT_WIDTH product, then an arithmetic shift right by DECIMAL_WIDTH (floor toward −∞). grad_out = q[BIT_WIDTH-1:0]. No saturation is needed because |p| ≤ 0.25. Register grad_out, v3.
- out_valid = v3.
- range_err:
  - Reset clears it to 0.
  - clear_err=1 clears it at the next edge.
  - If a clamp and clear_err occur in the same cycle, set wins and range_err ends at 1.
  - Otherwise range_err holds its value.
- Stalled registers hold their data and valid unchanged. No transfer is lost or duplicated. Output order equals input order.

## Timing
- Reset values: out_valid=0, grad_out=0, range_err=0, all valid bits 0. in_ready=1 once reset deasserts, since out_valid=0.
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+3 when en stays high.
- Throughput: 1 result/cycle with out_ready held high.
- Backpressure:
  - With out_valid=1 and out_ready=0, in_ready=0 in that same cycle, and the whole pipeline freezes.
  - Raising out_ready restarts the pipeline that cycle. The output transfer and the new input acceptance happen on the same edge.
- Reset mid-operation: all in-flight data is discarded immediately. out_valid drops asynchronously, and grad_out=0.
- grad_out is stable while out_valid && !out_ready.

## Test plan
- **Basic value:** reset, then s=32768 (0.5), g=65536 (1.0), out_ready=1 → out_valid exactly 3 cycles after acceptance. Required: grad_out=16384, range_err=0.
- **Negative gradient:** s=49152 (0.75), g=−131072 (0xFFFE0000) → p=12288. Required: grad_out=−24576 (0xFFFFA000).
- **Truncation and floor:**
  - s=6554, g=−65536 → p=5898. Required: grad_out=−5898.
  - s=6554, g=−1 (0xFFFFFFFF). Required: grad_out=−1 (0xFFFFFFFF), floor not toward zero.
- **Range clamp:**
  - s=−100, g=65536. Required: grad_out=0, range_err=1 at the acceptance edge.
  - s=131072 (2.0). Required: grad_out=0.
  - Pulse clear_err. Required: range_err=0.
  - Assert a clamped input and clear_err in the same cycle. Required: range_err=1.
- **Backpressure:**
  - Stream 6 inputs back-to-back with out_ready=0. Required: exactly 4 accepted (3 stages filled, then stall; in_ready=0 once out_valid=1), and grad_out held constant.
  - Raise out_ready. Required: all accepted results emerge in order, none dropped or duplicated.
- **Reset mid-flight:** 3 items in flight, then assert reset asynchronously mid-cycle. Required: out_valid=0 and grad_out=0 without waiting for an edge; after release, the first new input has 3-cycle latency.
